vga_timing_receiver: RTL and testbench

VGA_TIMING_RECEIVER -- requirements
Module: vga_timing_receiver

---
 rtl/vga_pkg.sv | 20 ++
 rtl/vga_rx_edge_det.sv | 32 +++
 rtl/vga_timing_receiver.sv | 308 ++++++++++++++++++++++++++++++
 tb/tb_vga_timing_receiver.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA timing receiver: default coordinate width,
// receiver FSM state encoding and 1080p reference timing constants.
package vga_pkg;

  localparam int unsigned COORD_W_DEFAULT = 12;

  // 1080p60 (CEA-861) totals and active region.
  localparam int unsigned H_TOTAL_1080P  = 2200;
  localparam int unsigned V_TOTAL_1080P  = 1125;
  localparam int unsigned H_ACTIVE_1080P = 1920;
  localparam int unsigned V_ACTIVE_1080P = 1080;

  typedef enum logic [1:0] {
    StSearch,
    StMeasure,
    StVerify,
    StLocked
  } vga_state_e;

endpackage

// File: rtl/vga_rx_edge_det.sv
// Input register with rising/falling edge pulses derived from the registered
// copy. Edge pulses stay masked for two cycles after reset so that a level
// already present at reset release is not mistaken for an edge.
module vga_rx_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic       q_prev;
  logic [1:0] arm_q;

  // Capture the input, keep one cycle of history and fill the arm mask.
  always_ff @(posedge clk) begin
    if (reset) begin
      q      <= 1'b0;
      q_prev <= 1'b0;
      arm_q  <= 2'b00;
    end else begin
      q      <= d;
      q_prev <= q;
      arm_q  <= {arm_q[0], 1'b1};
    end
  end

  assign rise = arm_q[1] & q & ~q_prev;
  assign fall = arm_q[1] & ~q & q_prev;

endmodule

// File: rtl/vga_timing_receiver.sv
// VGA timing receiver: recovers pixel coordinates from h_sync/v_sync/DE,
// measures line/frame timing and locks once timing is stable.
// Optional build macro: VGA_RX_POLARITY_DETECT_EN enables sync polarity
// learning while searching; without it both syncs are active-high.
module vga_timing_receiver
  import vga_pkg::*;
#(
  parameter int unsigned LOCK_FRAMES = 2,
  parameter int unsigned COORD_W     = COORD_W_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               h_sync,
  input  logic               v_sync,
  input  logic               video_enable,
  output logic [COORD_W-1:0] x_idx,
  output logic [COORD_W-1:0] y_idx,
  output logic               pixel_valid,
  output logic               frame_start,
  output logic [COORD_W-1:0] h_total_meas,
  output logic [COORD_W-1:0] v_total_meas,
  output logic [COORD_W-1:0] h_active_meas,
  output logic [COORD_W-1:0] v_active_meas,
  output logic               locked,
  output logic               lock_err
);

  localparam logic [COORD_W-1:0] CoordMax = '1;
  localparam int unsigned CntW = $clog2(LOCK_FRAMES + 1);

  function automatic logic [COORD_W-1:0] sat_inc(input logic [COORD_W-1:0] v);
    return (v == CoordMax) ? v : v + 1'b1;
  endfunction

  logic hs_lvl, hs_rise, hs_fall;
  logic vs_lvl, vs_rise, vs_fall;
  logic de_lvl, de_rise, de_fall;
  logic hs_inv, vs_inv, pol_ok;
  logic hs_edge, vs_edge;

  vga_state_e state_q, state_d;

  vga_rx_edge_det u_hs_det (
    .clk  (clk),
    .reset(reset),
    .d    (h_sync),
    .q    (hs_lvl),
    .rise (hs_rise),
    .fall (hs_fall)
  );

  vga_rx_edge_det u_vs_det (
    .clk  (clk),
    .reset(reset),
    .d    (v_sync),
    .q    (vs_lvl),
    .rise (vs_rise),
    .fall (vs_fall)
  );

  vga_rx_edge_det u_de_det (
    .clk  (clk),
    .reset(reset),
    .d    (video_enable),
    .q    (de_lvl),
    .rise (de_rise),
    .fall (de_fall)
  );

`ifdef VGA_RX_POLARITY_DETECT_EN
  logic               hs_inv_q, vs_inv_q;
  logic [1:0]         hs_seen_q, vs_seen_q;
  logic [COORD_W-1:0] hs_hi_q, hs_lo_q, vs_hi_q, vs_lo_q;

  // Learn polarity over whole sync periods while searching; the longer level
  // is the inactive one. Vertical levels are counted in lines.
  always_ff @(posedge clk) begin
    if (reset) begin
      hs_inv_q  <= 1'b0;
      vs_inv_q  <= 1'b0;
      hs_seen_q <= 2'd0;
      vs_seen_q <= 2'd0;
      hs_hi_q   <= '0;
      hs_lo_q   <= '0;
      vs_hi_q   <= '0;
      vs_lo_q   <= '0;
    end else if (state_q == StSearch) begin
      if (hs_rise) begin
        if (hs_seen_q != 2'd0) hs_inv_q <= (hs_hi_q > hs_lo_q);
        if (hs_seen_q != 2'd2) hs_seen_q <= hs_seen_q + 2'd1;
        hs_hi_q <= '0;
        hs_lo_q <= '0;
      end else if (hs_lvl) begin
        hs_hi_q <= sat_inc(hs_hi_q);
      end else begin
        hs_lo_q <= sat_inc(hs_lo_q);
      end
      if (vs_rise) begin
        if (vs_seen_q != 2'd0) vs_inv_q <= (vs_hi_q > vs_lo_q);
        if (vs_seen_q != 2'd2) vs_seen_q <= vs_seen_q + 2'd1;
        vs_hi_q <= '0;
        vs_lo_q <= '0;
      end else if (hs_rise) begin
        if (vs_lvl) vs_hi_q <= sat_inc(vs_hi_q);
        else        vs_lo_q <= sat_inc(vs_lo_q);
      end
    end
  end

  assign hs_inv = hs_inv_q;
  assign vs_inv = vs_inv_q;
  assign pol_ok = hs_seen_q[1] & vs_seen_q[1];
`else
  logic unused_lvl;
  assign unused_lvl = ^{hs_lvl, vs_lvl};
  assign hs_inv = 1'b0;
  assign vs_inv = 1'b0;
  assign pol_ok = 1'b1;
`endif

  // Active edge is the rising edge of the polarity-corrected sync.
  assign hs_edge = hs_inv ? hs_fall : hs_rise;
  assign vs_edge = vs_inv ? vs_fall : vs_rise;

  // ---------------------------------------------------------------------------
  // Timing counters
  // ---------------------------------------------------------------------------
  logic [COORD_W-1:0] h_cnt_q, v_cnt_q, h_last_q, h_act_last_q, v_act_q;
  logic [COORD_W-1:0] x_q, y_q, x_d, y_d;
  logic               sat_q, sat_now, sat_frame;
  logic [COORD_W-1:0] f_h_total, f_v_total, f_h_active, f_v_active;

  assign sat_now   = (h_cnt_q == CoordMax) | (v_cnt_q == CoordMax);
  assign sat_frame = sat_q | sat_now;

  // Frame totals as seen at a v_sync edge; a coincident h_sync edge or DE fall
  // belongs to the frame that is ending.
  assign f_h_total  = hs_edge ? h_cnt_q : h_last_q;
  assign f_v_total  = hs_edge ? sat_inc(v_cnt_q) : v_cnt_q;
  assign f_h_active = de_fall ? sat_inc(x_q) : h_act_last_q;
  assign f_v_active = de_fall ? sat_inc(v_act_q) : v_act_q;

  // Line/frame counters; h_cnt holds the clock count of the line ending now.
  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt_q      <= '0;
      v_cnt_q      <= '0;
      h_last_q     <= '0;
      h_act_last_q <= '0;
      v_act_q      <= '0;
      sat_q        <= 1'b0;
    end else begin
      h_cnt_q <= hs_edge ? COORD_W'(1) : sat_inc(h_cnt_q);
      if (hs_edge) h_last_q <= h_cnt_q;
      if (de_fall) h_act_last_q <= sat_inc(x_q);
      if (vs_edge) begin
        v_cnt_q <= '0;
        v_act_q <= '0;
      end else begin
        if (hs_edge) v_cnt_q <= sat_inc(v_cnt_q);
        if (de_fall) v_act_q <= sat_inc(v_act_q);
      end
      sat_q <= vs_edge ? 1'b0 : sat_frame;
    end
  end

  // Publish the completed frame's timing unless a counter saturated in it.
  always_ff @(posedge clk) begin
    if (reset) begin
      h_total_meas  <= '0;
      v_total_meas  <= '0;
      h_active_meas <= '0;
      v_active_meas <= '0;
    end else if (vs_edge && !sat_frame) begin
      h_total_meas  <= f_h_total;
      v_total_meas  <= f_v_total;
      h_active_meas <= f_h_active;
      v_active_meas <= f_v_active;
    end
  end

  // ---------------------------------------------------------------------------
  // Lock FSM
  // ---------------------------------------------------------------------------
  logic [COORD_W-1:0] ref_h_q, ref_v_q, ref_ha_q, ref_va_q;
  logic [CntW-1:0]    match_q, match_d;
  logic               ref_load, lose_lock, frame_match;
  logic               locked_d, lock_err_d;

  assign frame_match = (f_h_total == ref_h_q) && (f_v_total == ref_v_q) &&
                       (f_h_active == ref_ha_q) && (f_v_active == ref_va_q);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= StSearch;
    else       state_q <= state_d;
  end

  // Next-state logic with reference reload and match counting.
  always_comb begin
    state_d   = state_q;
    match_d   = match_q;
    ref_load  = 1'b0;
    lose_lock = 1'b0;
    unique case (state_q)
      StSearch: begin
        if (vs_edge && pol_ok) state_d = StMeasure;
      end
      StMeasure: begin
        if (sat_frame) begin
          state_d = StSearch;
        end else if (vs_edge) begin
          ref_load = 1'b1;
          match_d  = CntW'(1);
          state_d  = (LOCK_FRAMES <= 1) ? StLocked : StVerify;
        end
      end
      StVerify: begin
        if (sat_frame) begin
          state_d = StSearch;
        end else if (vs_edge) begin
          if (frame_match) begin
            match_d = match_q + 1'b1;
          end else begin
            ref_load = 1'b1;
            match_d  = CntW'(1);
          end
          if (match_d >= CntW'(LOCK_FRAMES)) state_d = StLocked;
        end
      end
      StLocked: begin
        if (sat_frame || (hs_edge && (h_cnt_q != ref_h_q)) || (vs_edge && !frame_match)) begin
          state_d   = StSearch;
          lose_lock = 1'b1;
        end
      end
      default: state_d = StSearch;
    endcase
  end

  // Lock outputs follow the next state so they change with the state register.
  always_comb begin
    locked_d   = (state_d == StLocked);
    lock_err_d = lose_lock;
  end

  // Reference timing, match count and registered lock outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      ref_h_q  <= '0;
      ref_v_q  <= '0;
      ref_ha_q <= '0;
      ref_va_q <= '0;
      match_q  <= '0;
      locked   <= 1'b0;
      lock_err <= 1'b0;
    end else begin
      if (ref_load) begin
        ref_h_q  <= f_h_total;
        ref_v_q  <= f_v_total;
        ref_ha_q <= f_h_active;
        ref_va_q <= f_v_active;
      end
      match_q  <= match_d;
      locked   <= locked_d;
      lock_err <= lock_err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Pixel coordinates
  // ---------------------------------------------------------------------------
  logic pend_q, pv_q, fs_q, fs_d;

  // x restarts on DE rise; y restarts on the first active line after v_sync.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (de_lvl) x_d = de_rise ? '0 : x_q + 1'b1;
    if (de_rise && (pend_q || vs_edge)) y_d = '0;
    else if (de_fall)                   y_d = y_q + 1'b1;
    fs_d = de_rise && (y_d == '0);
  end

  // Coordinate and pixel strobe registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_q    <= '0;
      y_q    <= '0;
      pend_q <= 1'b0;
      pv_q   <= 1'b0;
      fs_q   <= 1'b0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      pv_q   <= de_lvl;
      fs_q   <= fs_d;
      if (de_rise)      pend_q <= 1'b0;
      else if (vs_edge) pend_q <= 1'b1;
    end
  end

  assign x_idx       = x_q;
  assign y_idx       = y_q;
  assign pixel_valid = pv_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_timing_receiver.sv
// Directed bench for vga_timing_receiver using a scaled-down raster
// (40 clocks x 20 lines, DE 24 x 12) so each frame is only 800 clocks.
module tb_vga_timing_receiver;
  import vga_pkg::*;

  localparam int unsigned CW = 12;

  logic          clk, reset, h_sync, v_sync, video_enable;
  logic [CW-1:0] x_idx, y_idx, h_total_meas, v_total_meas, h_active_meas, v_active_meas;
  logic          pixel_valid, frame_start, locked, lock_err;

  vga_timing_receiver #(
    .LOCK_FRAMES(2),
    .COORD_W    (CW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .h_sync       (h_sync),
    .v_sync       (v_sync),
    .video_enable (video_enable),
    .x_idx        (x_idx),
    .y_idx        (y_idx),
    .pixel_valid  (pixel_valid),
    .frame_start  (frame_start),
    .h_total_meas (h_total_meas),
    .v_total_meas (v_total_meas),
    .h_active_meas(h_active_meas),
    .v_active_meas(v_active_meas),
    .locked       (locked),
    .lock_err     (lock_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Stream position and observations.
  int          cyc, col, line, h_len;
  bit          inv, stall, shorten_req, short_pending;
  int          vs_cyc[$];
  int          lock_cyc, err_cnt, err_cyc, short_cyc, fs_cnt, pv_cnt, fp_drv, lp_drv;
  logic [63:0] first_obs, last_obs;
  logic [1:0]  st_at_err;
  logic        locked_at_err, locked_prev;

  localparam logic [63:0] MeasExp = 64'({12'd40, 12'd20, 12'd24, 12'd12});

  task automatic clear_obs();
    vs_cyc.delete();
    lock_cyc      = -1;
    err_cnt       = 0;
    err_cyc       = -1;
    short_cyc     = -100;
    fs_cnt        = 0;
    pv_cnt        = 0;
    fp_drv        = -100;
    lp_drv        = -100;
    first_obs     = '1;
    last_obs      = '1;
    st_at_err     = 2'b11;
    locked_at_err = 1'b1;
  endtask

  // One clock: observe outputs at the falling edge, then drive the next inputs.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (locked && !locked_prev && lock_cyc < 0) lock_cyc = cyc;
    locked_prev = locked;
    if (lock_err) begin
      err_cnt++;
      if (err_cyc < 0) begin
        err_cyc       = cyc;
        st_at_err     = dut.state_q;
        locked_at_err = locked;
      end
    end
    if (frame_start) fs_cnt++;
    if (pixel_valid) pv_cnt++;
    if (cyc == fp_drv + 2) first_obs = 64'({frame_start, pixel_valid, x_idx, y_idx});
    if (cyc == lp_drv + 2) last_obs = 64'({pixel_valid, x_idx, y_idx});
    if (stall) begin
      h_sync       = inv;
      v_sync       = inv;
      video_enable = 1'b0;
    end else begin
      if (col == 0) begin
        h_len = 40;
        if (line == 7 && shorten_req) begin
          h_len         = 39;
          shorten_req   = 1'b0;
          short_pending = 1'b1;
        end
        if (line == 8 && short_pending) begin
          short_cyc     = cyc;
          short_pending = 1'b0;
        end
        if (line == 0) vs_cyc.push_back(cyc);
      end
      h_sync       = (col < 4) ^ inv;
      v_sync       = (line < 2) ^ inv;
      video_enable = (line >= 4) && (line < 16) && (col >= 10) && (col < 34);
      if (line == 4 && col == 10) fp_drv = cyc;
      if (line == 15 && col == 33) lp_drv = cyc;
      col++;
      if (col == h_len) begin
        col  = 0;
        line = (line == 19) ? 0 : line + 1;
      end
    end
  endtask

  task automatic check_lock_timing(input string tag);
    int exp_cyc;
    check_val({tag, "_vs_edges"}, 64'(vs_cyc.size() >= 3), 64'(1));
    exp_cyc = (vs_cyc.size() >= 3) ? vs_cyc[2] + 2 : -2;
    check_val({tag, "_lock_cycle"}, 64'(lock_cyc), 64'(exp_cyc));
  endtask

  task automatic check_zero_outputs(input string tag);
    check_val({tag, "_pix"}, 64'({frame_start, pixel_valid, x_idx, y_idx}), 64'(0));
    check_val({tag, "_lock"}, 64'({locked, lock_err}), 64'(0));
    check_val({tag, "_meas"},
              64'({h_total_meas, v_total_meas, h_active_meas, v_active_meas}), 64'(0));
  endtask

  initial begin
    reset         = 1'b1;
    h_sync        = 1'b0;
    v_sync        = 1'b0;
    video_enable  = 1'b0;
    inv           = 1'b0;
    stall         = 1'b0;
    shorten_req   = 1'b0;
    short_pending = 1'b0;
    col           = 0;
    line          = 19;
    h_len         = 40;
    cyc           = 0;
    locked_prev   = 1'b0;
    clear_obs();

    repeat (3) tick();
    check_zero_outputs("rst");
    reset = 1'b0;
    clear_obs();

    // Lock acquisition: locked rises two clocks after the third v_sync edge.
    repeat (3200) tick();
    check_lock_timing("acq");
    check_val("acq_meas", 64'({h_total_meas, v_total_meas, h_active_meas, v_active_meas}),
              MeasExp);
    check_val("acq_locked", 64'(locked), 64'(1));

    // One full frame of pixel output.
    clear_obs();
    repeat (800) tick();
    check_val("pix_first", first_obs, 64'({1'b1, 1'b1, 12'd0, 12'd0}));
    check_val("pix_last", last_obs, 64'({1'b1, 12'd23, 12'd11}));
    check_val("pix_fs_count", 64'(fs_cnt), 64'(1));
    check_val("pix_pv_count", 64'(pv_cnt), 64'(288));

    // One line shortened to 39 clocks while locked.
    clear_obs();
    shorten_req = 1'b1;
    repeat (800) tick();
    check_val("short_err_count", 64'(err_cnt), 64'(1));
    check_val("short_err_cycle", 64'(err_cyc), 64'(short_cyc + 2));
    check_val("short_state", 64'(st_at_err), 64'(StSearch));
    check_val("short_locked", 64'(locked_at_err), 64'(0));

    // Relock, then reset mid-frame.
    clear_obs();
    repeat (2400) tick();
    check_val("relock_pre", 64'(locked), 64'(1));
    repeat (400) tick();
    reset = 1'b1;
    tick();
    check_zero_outputs("midrst");
    reset = 1'b0;
    clear_obs();
    repeat (3200) tick();
    check_lock_timing("midrst");
    check_val("midrst_meas",
              64'({h_total_meas, v_total_meas, h_active_meas, v_active_meas}), MeasExp);

    // h_sync stuck inactive: horizontal counter saturates and lock drops.
    clear_obs();
    stall = 1'b1;
    repeat (5000) tick();
    check_val("stall_err_count", 64'(err_cnt), 64'(1));
    check_val("stall_locked", 64'(locked), 64'(0));
    check_val("stall_state", 64'(dut.state_q), 64'(StSearch));
    check_val("stall_meas",
              64'({h_total_meas, v_total_meas, h_active_meas, v_active_meas}), MeasExp);
    stall = 1'b0;
    repeat (1600) tick();
    check_val("resume_meas",
              64'({h_total_meas, v_total_meas, h_active_meas, v_active_meas}), MeasExp);

`ifdef VGA_RX_POLARITY_DETECT_EN
    // Inverted syncs must still lock with identical measurements.
    inv   = 1'b1;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    clear_obs();
    repeat (4800) tick();
    check_val("inv_locked", 64'(locked), 64'(1));
    check_val("inv_meas",
              64'({h_total_meas, v_total_meas, h_active_meas, v_active_meas}), MeasExp);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
